// File: rtl/pipe_mmio_ports.sv
// pipe_mmio_ports -- memory-mapped I/O unit for the MEM stage of the pipeline.
//
// Word map relative to IO_BASE (k = word offset, malu[1:0] ignored):
//   k <  N_IN                 IN[k]      synchronised input sample (read-only)
//   N_IN <= k < N_IN+N_OUT    OUT[k-N_IN] output register (R/W)
//   k == N_IN+N_OUT           CHG        sticky change flags, write-1-to-clear
//   k == N_IN+N_OUT+1         MASK       interrupt mask for CHG (R/W)
//
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   mwmem, malu, mb    MEM-stage store strobe, byte address, store data
//   in_ports           N_IN packed external inputs (asynchronous to clock)
//   out_ports          N_OUT packed output registers
//   io_sel             combinational: malu inside the I/O window
//   io_rdata           combinational read data (0 outside the window)
//   chg_irq            registered: any unmasked change flag set
module pipe_mmio_ports #(
   parameter int          DATA_W      = 32,
   parameter int          N_IN        = 2,
   parameter int          N_OUT       = 2,
   parameter logic [31:0] IO_BASE     = 32'h0000_0080,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    mwmem,
   input  logic [31:0]             malu,
   input  logic [DATA_W-1:0]       mb,
   input  logic [N_IN*DATA_W-1:0]  in_ports,
   output logic [N_OUT*DATA_W-1:0] out_ports,
   output logic                    io_sel,
   output logic [DATA_W-1:0]       io_rdata,
   output logic                    chg_irq
);

   localparam logic [29:0] K_OUT   = 30'(N_IN);
   localparam logic [29:0] K_CHG   = 30'(N_IN + N_OUT);
   localparam logic [29:0] K_MASK  = 30'(N_IN + N_OUT + 1);
   localparam logic [29:0] K_END   = 30'(N_IN + N_OUT + 2);
   localparam int          PRIME_N = SYNC_STAGES + 1;
   localparam int          CNT_W   = $clog2(PRIME_N + 1);

   logic [DATA_W-1:0] sync_q [N_IN][SYNC_STAGES];
   logic [DATA_W-1:0] prev_q [N_IN];
   logic [DATA_W-1:0] out_q  [N_OUT];
   logic [DATA_W-1:0] out_d  [N_OUT];
   logic [N_IN-1:0]   chg_q, chg_d;
   logic [N_IN-1:0]   mask_q, mask_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              irq_q;

   logic [29:0]       k;
   logic              wr;
   logic              primed;
   logic              unused_addr_bits;

   // Byte lane bits do not take part in decoding.
   assign unused_addr_bits = ^malu[1:0];

   // IO_BASE is word aligned, so the word offset is a 30-bit subtraction.
   assign k      = malu[31:2] - IO_BASE[31:2];
   assign io_sel = (malu[31:2] >= IO_BASE[31:2]) && (k < K_END);
   assign wr     = mwmem & io_sel;
   assign primed = (cnt_q == CNT_W'(PRIME_N));

   // Read mux: zero-latency, zero outside the window.
   always_comb begin
      io_rdata = '0;
      if (io_sel) begin
         for (int i = 0; i < N_IN; i++)
            if (k == 30'(i)) io_rdata = sync_q[i][SYNC_STAGES-1];
         for (int j = 0; j < N_OUT; j++)
            if (k == K_OUT + 30'(j)) io_rdata = out_q[j];
         if (k == K_CHG)  io_rdata = DATA_W'(chg_q);
         if (k == K_MASK) io_rdata = DATA_W'(mask_q);
      end
   end

   // Next-state: stores, W1C, change detection and priming.
   always_comb begin
      out_d  = out_q;
      mask_d = mask_q;
      chg_d  = chg_q;
      cnt_d  = cnt_q;
      if (!primed) cnt_d = cnt_q + CNT_W'(1);
      for (int j = 0; j < N_OUT; j++)
         if (wr && (k == K_OUT + 30'(j))) out_d[j] = mb;
      if (wr && (k == K_MASK)) mask_d = mb[N_IN-1:0];
      if (wr && (k == K_CHG))  chg_d  = chg_q & ~mb[N_IN-1:0];
      // Setting is applied after the clear so a same-edge change wins.
      for (int i = 0; i < N_IN; i++)
         if (primed && (sync_q[i][SYNC_STAGES-1] != prev_q[i])) chg_d[i] = 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_IN; i++) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[i][s] <= '0;
            prev_q[i] <= '0;
         end
         for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
         chg_q  <= '0;
         mask_q <= '0;
         cnt_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            sync_q[i][0] <= in_ports[i*DATA_W +: DATA_W];
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[i][s] <= sync_q[i][s-1];
            // Before priming this simply tracks the sample, so power-up
            // values never raise a flag.
            prev_q[i] <= sync_q[i][SYNC_STAGES-1];
         end
         for (int j = 0; j < N_OUT; j++) out_q[j] <= out_d[j];
         chg_q  <= chg_d;
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
         irq_q  <= |(chg_q & mask_q);
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign out_ports[j*DATA_W +: DATA_W] = out_q[j];
   end

   assign chg_irq = irq_q;

endmodule
